// File: rtl/axi_ram_responder.sv
// axi_ram_responder
//   AXI4 slave backed by on-chip block RAM. It stands in for the DDR
//   controller's slave port. It services one burst at a time. Every burst is
//   treated as INCR of full-width beats. The size, burst, lock, cache, prot and
//   qos fields are ignored.
//
//   Optional feature: define AXI_RAM_RANGE_CHECK_EN to flag addresses whose
//   beat index lies beyond the RAM with SLVERR. Such writes are dropped and such
//   reads return zero data. When the macro is undefined, addresses alias
//   modulo the RAM size.
//
// Ports
//   CLK, rst_x_async     clock, asynchronous active-low reset
//   s_axi_aw*            write address channel (awready combinational in IDLE)
//   s_axi_w*             write data channel with byte strobes
//   s_axi_b*             write response channel
//   s_axi_ar*            read address channel (arready combinational in IDLE)
//   s_axi_r*             read data channel, one beat every two cycles
//   wlast_err            sticky: wlast disagreed with the beat count
//   dbg_state            current FSM state, for checkers
//
// Handshake semantics: a transfer happens on a rising CLK edge where both valid
// and ready are high. Once this block raises a valid (bvalid/rvalid), it holds
// that valid and its payload stable until the matching ready is seen.
module axi_ram_responder #(
  parameter int ADDR_WIDTH     = 28,
  parameter int DATA_WIDTH     = 128,
  parameter int ID_WIDTH       = 4,
  parameter int MEM_DEPTH_LOG2 = 12
) (
  input  logic                    CLK,
  input  logic                    rst_x_async,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awqos,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic                    wlast_err,
  output logic [2:0]              dbg_state
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int HI_LSB = OFF + MEM_DEPTH_LOG2;
  localparam int DEPTH  = 1 << MEM_DEPTH_LOG2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WDATA  = 3'd1,
    S_WRESP  = 3'd2,
    S_RFETCH = 3'd3,
    S_RDATA  = 3'd4
  } state_t;

  state_t state, state_nx;

  logic                      last_write;  // 1: the most recent grant was a write
  logic [ID_WIDTH-1:0]       id_q;
  logic [MEM_DEPTH_LOG2-1:0] idx_q;
  logic [7:0]                len_q;
  logic [7:0]                cnt_q;
  logic                      bad_q;       // burst address lies outside the RAM
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic [DATA_WIDTH-1:0]     mem [DEPTH];

  logic grant_w, grant_r;
  logic aw_bad, ar_bad;
  logic last_beat;

  // On a tie, grant the channel that did not win last time.
  assign grant_w   = s_axi_awvalid && (!s_axi_arvalid || !last_write);
  assign grant_r   = s_axi_arvalid && !grant_w;
  assign last_beat = (cnt_q == len_q);

`ifdef AXI_RAM_RANGE_CHECK_EN
  assign aw_bad = |s_axi_awaddr[ADDR_WIDTH-1:HI_LSB];
  assign ar_bad = |s_axi_araddr[ADDR_WIDTH-1:HI_LSB];
`else
  assign aw_bad = 1'b0;
  assign ar_bad = 1'b0;
`endif

  // Fields this responder deliberately ignores.
  logic unused_fields;
  assign unused_fields = ^{s_axi_awsize, s_axi_awburst, s_axi_awlock, s_axi_awcache,
                           s_axi_awprot, s_axi_awqos, s_axi_arsize, s_axi_arburst,
                           s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
                           s_axi_awaddr[OFF-1:0], s_axi_araddr[OFF-1:0],
                           s_axi_awaddr[ADDR_WIDTH-1:HI_LSB],
                           s_axi_araddr[ADDR_WIDTH-1:HI_LSB]};

  // Next state and channel handshake outputs.
  always_comb begin
    state_nx      = state;
    s_axi_awready = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (state)
      S_IDLE: begin
        s_axi_awready = grant_w;
        s_axi_arready = grant_r;
        if (grant_w)      state_nx = S_WDATA;
        else if (grant_r) state_nx = S_RFETCH;
      end
      S_WDATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && last_beat) state_nx = S_WRESP;
      end
      S_WRESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) state_nx = S_IDLE;
      end
      S_RFETCH: state_nx = S_RDATA;
      S_RDATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) state_nx = last_beat ? S_IDLE : S_RFETCH;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_x_async) begin
    if (!rst_x_async) begin
      state      <= S_IDLE;
      last_write <= 1'b0;
      id_q       <= '0;
      idx_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      bad_q      <= 1'b0;
      wlast_err  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (grant_w) begin
            last_write <= 1'b1;
            id_q       <= s_axi_awid;
            idx_q      <= s_axi_awaddr[OFF +: MEM_DEPTH_LOG2];
            len_q      <= s_axi_awlen;
            cnt_q      <= '0;
            bad_q      <= aw_bad;
          end else if (grant_r) begin
            last_write <= 1'b0;
            id_q       <= s_axi_arid;
            idx_q      <= s_axi_araddr[OFF +: MEM_DEPTH_LOG2];
            len_q      <= s_axi_arlen;
            cnt_q      <= '0;
            bad_q      <= ar_bad;
          end
        end
        S_WDATA: begin
          if (s_axi_wvalid) begin
            cnt_q <= cnt_q + 8'd1;
            idx_q <= idx_q + 1'b1;
            if (s_axi_wlast != last_beat) wlast_err <= 1'b1;
          end
        end
        S_RFETCH: rdata_q <= bad_q ? '0 : mem[idx_q];
        S_RDATA: begin
          if (s_axi_rready && !last_beat) begin
            cnt_q <= cnt_q + 8'd1;
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM write port: byte-granular, never reset.
  always_ff @(posedge CLK) begin
    if (state == S_WDATA && s_axi_wvalid && !bad_q) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) mem[idx_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  assign s_axi_bid   = id_q;
  assign s_axi_rid   = id_q;
  assign s_axi_rdata = rdata_q;
  assign s_axi_rlast = (state == S_RDATA) && last_beat;
  assign s_axi_bresp = (state == S_WRESP && bad_q) ? 2'b10 : 2'b00;
  assign s_axi_rresp = (state == S_RDATA && bad_q) ? 2'b10 : 2'b00;
  assign dbg_state   = state;

endmodule

// File: tb/tb_axi_ram_responder.sv
// Testbench for axi_ram_responder. The bench keeps a reference RAM image and a
// queue of expected read beats and write responses. A compare process checks
// every R and B handshake, and read stability, against these.
module tb_axi_ram_responder;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int IW = 4;
  localparam int SW = DW / 8;
  localparam int EW = IW + 2 + 1 + DW;
  localparam int BW = IW + 2;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic rst_x_async;
  always #5 CLK = ~CLK;

  logic [IW-1:0] awid, arid, bid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic          awvalid, awready, arvalid, arready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic          wlast, wvalid, wready;
  logic [1:0]    bresp, rresp;
  logic          bvalid, bready, rlast, rvalid, rready;
  logic          wlast_err;
  logic [2:0]    dbg_state;

  axi_ram_responder dut (
    .CLK(CLK), .rst_x_async(rst_x_async),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
    .s_axi_awsize(3'd4), .s_axi_awburst(2'b01), .s_axi_awlock(1'b0),
    .s_axi_awcache(4'd0), .s_axi_awprot(3'd0), .s_axi_awqos(4'd0),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(3'd4), .s_axi_arburst(2'b01), .s_axi_arlock(1'b0),
    .s_axi_arcache(4'd0), .s_axi_arprot(3'd0), .s_axi_arqos(4'd0),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .wlast_err(wlast_err), .dbg_state(dbg_state)
  );

  // ---------------- model and scoreboard ----------------
  logic [DW-1:0] mdl [0:4095];
  logic [EW-1:0] exp_q[$];
  logic [BW-1:0] exp_b_q[$];
  logic [DW-1:0] got_q[$];
  logic [1:0]    got_resp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            cur_widx;
  logic          cur_wbad;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic addr_bad(input logic [AW-1:0] a);
`ifdef AXI_RAM_RANGE_CHECK_EN
    return (a / 65536) != 0;
`else
    return (a != a);
`endif
  endfunction

  function automatic int addr_idx(input logic [AW-1:0] a);
    return int'((a / 16) % 4096);
  endfunction

  function automatic logic [DW-1:0] got_at(input int i);
    if (got_q.size() > i) return got_q[i];
    return 'x;
  endfunction

  task automatic aw_expect(input logic [IW-1:0] id, input logic [AW-1:0] addr);
    cur_widx = addr_idx(addr);
    cur_wbad = addr_bad(addr);
    exp_b_q.push_back({id, cur_wbad ? 2'b10 : 2'b00});
  endtask

  task automatic ar_expect(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len);
    logic bad;
    int idx;
    bad = addr_bad(addr);
    for (int i = 0; i <= len; i++) begin
      idx = (addr_idx(addr) + i) % 4096;
      exp_q.push_back({id, bad ? 2'b10 : 2'b00, (i == len) ? 1'b1 : 1'b0,
                       bad ? {DW{1'b0}} : mdl[idx]});
    end
  endtask

  // Compare process: checks the DUT on every cycle, once inputs have settled.
  logic          hold_valid = 1'b0;
  logic [EW-1:0] hold_val;
  always @(negedge CLK) begin
    #2;
    if (!rst_x_async) begin
      hold_valid = 1'b0;
    end else begin
      chk("ready_exclusive", {awready, arready} == 2'b11, 0);
      if (hold_valid)
        chk("r_stable", {rvalid, rid, rresp, rlast, rdata}, {1'b1, hold_val});
      if (rvalid && rready) begin
        if (exp_q.size() == 0) chk("r_unexpected", 1, 0);
        else chk("r_beat", {rid, rresp, rlast, rdata}, exp_q.pop_front());
        got_q.push_back(rdata);
        got_resp_q.push_back(rresp);
      end
      hold_valid = rvalid && !rready;
      hold_val   = {rid, rresp, rlast, rdata};
      if (bvalid && bready) begin
        if (exp_b_q.size() == 0) chk("b_unexpected", 1, 0);
        else chk("b_resp", {bid, bresp}, exp_b_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic aw_issue(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len);
    int n;
    @(negedge CLK);
    awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
    aw_expect(id, addr);
    #1;
    n = 0;
    while (!awready && n < 200) begin @(negedge CLK); #1; n++; end
    if (n >= 200) chk("aw_timeout", 1, 0);
    @(negedge CLK);
    awvalid = 1'b0;
    #1;
    chk("wready_lat", wready, 1);
  endtask

  task automatic w_beat(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic last,
                        input logic exp_bvalid);
    int n;
    @(negedge CLK);
    wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
    #1;
    n = 0;
    while (!wready && n < 200) begin @(negedge CLK); #1; n++; end
    if (n >= 200) chk("w_timeout", 1, 0);
    if (!cur_wbad)
      for (int b = 0; b < SW; b++)
        if (s[b]) mdl[cur_widx][b*8 +: 8] = d[b*8 +: 8];
    cur_widx = (cur_widx + 1) % 4096;
    @(negedge CLK);
    wvalid = 1'b0; wlast = 1'b0;
    #1;
    chk("bvalid_after_w", bvalid, exp_bvalid);
  endtask

  task automatic b_take();
    int n;
    @(negedge CLK);
    bready = 1'b1;
    #1;
    n = 0;
    while (!bvalid && n < 200) begin @(negedge CLK); #1; n++; end
    if (n >= 200) chk("b_timeout", 1, 0);
    @(negedge CLK);
    bready = 1'b0;
  endtask

  task automatic ar_issue(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic check_lat);
    int n;
    @(negedge CLK);
    arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
    ar_expect(id, addr, int'(len));
    #1;
    n = 0;
    while (!arready && n < 200) begin @(negedge CLK); #1; n++; end
    if (n >= 200) chk("ar_timeout", 1, 0);
    @(negedge CLK);
    arvalid = 1'b0;
    #1;
    if (check_lat) begin
      chk("rvalid_t1", rvalid, 0);
      @(negedge CLK);
      #1;
      chk("rvalid_t2", rvalid, 1);
    end
  endtask

  // mode 0: rready always high; mode 1: rready high one cycle in three.
  task automatic r_take(input int len, input int mode);
    int got, k;
    got = 0; k = 0;
    while (got <= len && k < 300) begin
      @(negedge CLK);
      rready = (mode == 0) || (k % 3 == 2);
      #1;
      if (rvalid && rready) got++;
      k++;
    end
    if (got <= len) chk("r_timeout", 1, 0);
    @(negedge CLK);
    rready = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ctl"}, {awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, wlast_err}, 0);
    chk({tag, "_ids"}, {bid, rid}, 0);
    chk({tag, "_rdata"}, rdata, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 4096; i++) mdl[i] = '0;
    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b0; rready = 1'b0;
    rst_x_async = 1'b0;
    repeat (3) @(negedge CLK);
    #1 reset_checks("reset0");
    @(negedge CLK) rst_x_async = 1'b1;

    // Single write then read.
    aw_issue(4'h3, 28'h100, 8'd0);
    w_beat(128'h0123456789ABCDEF0123456789ABCDEF, '1, 1'b1, 1'b1);
    b_take();
    got_q.delete();
    ar_issue(4'h6, 28'h100, 8'd0, 1'b1);
    r_take(0, 0);
    chk("single_rdata", got_at(0), 128'h0123456789ABCDEF0123456789ABCDEF);

    // Strobe merge.
    aw_issue(4'h1, 28'h200, 8'd0);
    w_beat('1, '1, 1'b1, 1'b1);
    b_take();
    aw_issue(4'h1, 28'h200, 8'd0);
    w_beat('0, 16'h00FF, 1'b1, 1'b1);
    b_take();
    got_q.delete();
    ar_issue(4'h2, 28'h200, 8'd0, 1'b0);
    r_take(0, 0);
    chk("strobe_merge", got_at(0), {64'hFFFF_FFFF_FFFF_FFFF, 64'h0});

    // Burst wrapping past the end of the RAM, read back with rready stalls.
    aw_issue(4'hA, 28'hFFE0, 8'd3);
    for (int i = 0; i < 4; i++) w_beat(DW'(i + 1), '1, i == 3, i == 3);
    b_take();
    got_q.delete();
    ar_issue(4'hB, 28'hFFE0, 8'd3, 1'b0);
    r_take(3, 1);
    for (int i = 0; i < 4; i++) chk("wrap_beat", got_at(i), DW'(i + 1));
    got_q.delete();
    ar_issue(4'hC, 28'h0, 8'd1, 1'b0);
    r_take(1, 0);
    chk("wrap_idx0", got_at(0), 128'd3);
    chk("wrap_idx1", got_at(1), 128'd4);

    // wlast on the first of two beats.
    aw_issue(4'h5, 28'h300, 8'd1);
    w_beat(128'h11, '1, 1'b1, 1'b0);
    chk("wlast_err_set", wlast_err, 1);
    w_beat(128'h22, '1, 1'b1, 1'b1);
    b_take();

    // Reset clears the sticky flag and the last-grant flag.
    @(negedge CLK) rst_x_async = 1'b0;
    repeat (2) @(negedge CLK);
    #1 reset_checks("reset1");
    @(negedge CLK) rst_x_async = 1'b1;

    // Tie 1 after reset: write first.
    @(negedge CLK);
    awid = 4'h1; awaddr = 28'h400; awlen = 8'd0; awvalid = 1'b1;
    arid = 4'h2; araddr = 28'h400; arlen = 8'd0; arvalid = 1'b1;
    aw_expect(4'h1, 28'h400);
    #1 chk("tie1_grant", {awready, arready}, 2'b10);
    @(negedge CLK);
    awvalid = 1'b0; arvalid = 1'b0;
    #1 chk("tie1_wready", wready, 1);
    w_beat({8{16'hAAAA}}, '1, 1'b1, 1'b1);
    b_take();
    got_q.delete();
    ar_issue(4'h2, 28'h400, 8'd0, 1'b0);
    r_take(0, 0);
    chk("tie1_rdata", got_at(0), {8{16'hAAAA}});

    // Tie 2, last grant was a read: write again. The read waiting behind it
    // is granted right after the B handshake and sees the new data.
    @(negedge CLK);
    awid = 4'h3; awaddr = 28'h410; awlen = 8'd0; awvalid = 1'b1;
    arid = 4'h4; araddr = 28'h400; arlen = 8'd0; arvalid = 1'b1;
    aw_expect(4'h3, 28'h410);
    #1 chk("tie2_grant", {awready, arready}, 2'b10);
    @(negedge CLK);
    awvalid = 1'b0; arvalid = 1'b0;
    w_beat({8{16'h5555}}, '1, 1'b1, 1'b1);
    @(negedge CLK);
    arid = 4'h4; araddr = 28'h410; arlen = 8'd0; arvalid = 1'b1;
    ar_expect(4'h4, 28'h410, 0);
    b_take();
    #1 chk("ar_after_b", arready, 1);
    @(negedge CLK) arvalid = 1'b0;
    got_q.delete();
    r_take(0, 0);
    chk("order_rdata", got_at(0), {8{16'h5555}});

    // Tie 3, last grant was a write: read wins.
    aw_issue(4'h5, 28'h420, 8'd0);
    w_beat(128'h77, '1, 1'b1, 1'b1);
    b_take();
    @(negedge CLK);
    awid = 4'h6; awaddr = 28'h420; awlen = 8'd0; awvalid = 1'b1;
    arid = 4'h7; araddr = 28'h420; arlen = 8'd0; arvalid = 1'b1;
    ar_expect(4'h7, 28'h420, 0);
    #1 chk("tie3_grant", {awready, arready}, 2'b01);
    @(negedge CLK);
    awvalid = 1'b0; arvalid = 1'b0;
    got_q.delete();
    r_take(0, 0);
    chk("tie3_rdata", got_at(0), 128'h77);

    // Read with beat-index bit 12 set.
    got_q.delete();
    got_resp_q.delete();
    ar_issue(4'h9, 28'h10000, 8'd0, 1'b0);
    r_take(0, 0);
`ifdef AXI_RAM_RANGE_CHECK_EN
    chk("range_rdata", got_at(0), 128'd0);
    chk("range_rresp", (got_resp_q.size() > 0) ? got_resp_q[0] : 2'bxx, 2'b10);
`else
    chk("alias_rdata", got_at(0), 128'd3);
    chk("alias_rresp", (got_resp_q.size() > 0) ? got_resp_q[0] : 2'bxx, 2'b00);
`endif

    repeat (3) @(negedge CLK);
    chk("exp_r_drained", exp_q.size(), 0);
    chk("exp_b_drained", exp_b_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/axi_ram_responder.md
# axi_ram_responder

AXI4 full-protocol slave that answers the SoC's 128-bit memory master from on-chip block RAM. It stands in for the DDR4 controller's AXI slave port on boards without DDR and in fast simulation, with an identical port set on the `s_axi_*` bundle. It services one burst at a time: write bursts with byte strobes, read bursts with per-beat flow control, and alternating priority between reads and writes.

## Interface
- `ADDR_WIDTH`, 28: byte address width.
- `DATA_WIDTH`, 128: beat width in bits (power of two, ≥32).
- `ID_WIDTH`, 4: transaction ID width.
- `MEM_DEPTH_LOG2`, 12: log2 of RAM depth in beats (4096 × 16 B = 64 KiB).

Ports:
- `CLK` in 1: clock for the entire block.
- `rst_x_async` in 1: reset, asynchronous, active-low.
- `s_axi_awid`/`awaddr`/`awlen`/`awsize`/`awburst`/`awlock`/`awcache`/`awprot`/`awqos` in: ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3/4 bits. Write address channel.
- `s_axi_awvalid` in 1 / `s_axi_awready` out 1: write address handshake.
- `s_axi_wdata` in DATA_WIDTH, `s_axi_wstrb` in DATA_WIDTH/8, `s_axi_wlast` in 1, `s_axi_wvalid` in 1, `s_axi_wready` out 1: write data channel.
- `s_axi_bid` out ID_WIDTH, `s_axi_bresp` out 2, `s_axi_bvalid` out 1, `s_axi_bready` in 1: write response channel.
- `s_axi_ar*` in: same fields and widths as AW. `s_axi_arvalid` in 1, `s_axi_arready` out 1.
- `s_axi_rid` out ID_WIDTH, `s_axi_rdata` out DATA_WIDTH, `s_axi_rresp` out 2, `s_axi_rlast` out 1, `s_axi_rvalid` out 1, `s_axi_rready` in 1: read data channel.
- `wlast_err` out 1: sticky flag, set when `wlast` disagrees with the beat count.

## Operation
- **States:** IDLE, WDATA, WRESP, RFETCH, RDATA.
- **Ignored fields:** size, burst, lock, cache, prot and qos are ignored. Every burst is treated as INCR of full-width beats.
- **Beat index:** `awaddr`/`araddr` bits [ADDR_WIDTH-1 : log2(DATA_WIDTH/8)], truncated to MEM_DEPTH_LOG2 bits. The index increments by 1 per beat and wraps modulo the RAM depth.
- **Arbitration in IDLE:**
  - Only AW valid: grant write. Only AR valid: grant read.
  - Both valid: grant the opposite of the last grant. The last-grant flag resets to "read", so the first tie goes to write.
- **IDLE → WDATA:** on the AW handshake, latch ID, index and len; clear the beat counter.
- **WDATA:** `wready`=1. On each W handshake, write bytes whose `wstrb` bit is 1 and increment the counter.
  - When counter == len, go to WRESP.
  - If `wlast` is 1 on an earlier beat, or 0 on that final beat, set `wlast_err`.
- **WRESP:** `bvalid`=1 with the latched `bid`. On `bready`, go to IDLE.
- **IDLE → RFETCH:** on the AR handshake, latch ID, index and len. RFETCH issues the RAM read.
- **RDATA:** `rvalid`=1, and `rlast`=1 on beat len. On `rready`, go to RFETCH for the next beat, or to IDLE after the last beat.
- **Responses:** `bresp`/`rresp` = 2'b00 (OKAY) unless the range check below applies.
- **Reset:**
  - All outputs are 0 and the state is IDLE; the last-grant flag and `wlast_err` are cleared.
  - RAM contents are not reset.
  - Reset asserted mid-burst aborts the burst with no response.

## Timing
- `awready`/`arready` are combinational in IDLE, asserted only toward the granted channel. Never both high in one cycle.
- **Write latency:** AW handshake at T; `wready`=1 from T+1. Last W beat at U; `bvalid`=1 at U+1.
- **Read latency:** AR handshake at T; `rvalid`=1 at T+2. `rvalid` drops for one cycle between beats, so throughput is one beat per 2 cycles.
- **Read stability:** while `rvalid`=1 and `rready`=0, `rdata`, `rid`, `rlast` and `rresp` hold stable.
- **Write-read ordering:** a write's data is visible to a read granted the cycle after `bvalid`/`bready`.
- **Stall tolerance:** `wvalid` low stalls WDATA indefinitely, and `bready`/`rready` low stall indefinitely.

## Configuration
- **`AXI_RAM_RANGE_CHECK_EN` defined:**
  - Compare the address beat-index bits above MEM_DEPTH_LOG2 against 0 at AW/AR acceptance.
  - If nonzero, the burst still runs its full handshake: writes are dropped, `bresp`=2'b10, and every read beat has `rresp`=2'b10 with `rdata`=0.
- **Not defined:** upper bits are ignored, the address aliases modulo the RAM size, and responses are always OKAY.

## Test plan
- **Single write then read:**
  - Stimulus: write 0x0123…CDEF at awaddr 0x100 (awlen 0, all strobes), then read the same address.
  - Response: `bresp`=0 and `bid` echoes the request. `rdata` matches, `rlast`=1, and `rvalid` rises 2 cycles after the AR handshake.
- **Strobe merge:**
  - Stimulus: write all-ones, then write zeros with `wstrb`=0x00FF.
  - Response: read returns upper 8 bytes 0xFF and lower 8 bytes 0x00.
- **Burst wrap:**
  - Stimulus: awlen=3 at beat index 4094, data 1..4; then read the same burst with `rready` toggling.
  - Response: beats land at indices 4094, 4095, 0, 1. Read returns 1..4 with `rlast` only on the 4th beat, and data holds while `rready`=0.
- **Simultaneous AW/AR after reset:**
  - Response: write is granted first, then read. On the next tie, write is granted again (the read was granted last).
- **wlast mismatch:**
  - Stimulus: awlen=1 with `wlast` asserted on beat 0.
  - Response: `wlast_err`=1, and the burst still takes 2 beats before `bvalid`.
- **Range check (macro on):**
  - Stimulus: read at a beat index with bit 12 set.
  - Response: `rresp`=2'b10 and `rdata`=0. With the macro off, the same read returns the index-0 data with OKAY.
